// File: rtl/reorder_buffer_pkg.sv
// Shared constants for the reorder buffer: sizing, instruction type codes and
// entry state encodings.
package reorder_buffer_pkg;

    localparam int ROB_SIZE       = 8;
    localparam int ROB_SIZE_WIDTH = 3;

    // Instruction type codes (RV32I major opcodes)
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] L_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;

    typedef enum logic [1:0] {
        ROB_EMPTY  = 2'd0,
        ROB_ISSUED = 2'd1,
        ROB_READY  = 2'd2
    } rob_state_e;

    function automatic logic writes_rd(input logic [6:0] t);
        return !(t == S_TYPE || t == B_TYPE);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates RoB ids, captures CDB results,
// retires in program order and raises rob_clear on a branch mispredict.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE       = reorder_buffer_pkg::ROB_SIZE,
    parameter int ROB_SIZE_WIDTH = reorder_buffer_pkg::ROB_SIZE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [6:0]                issue_type,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_ready,
    input  logic [31:0]               issue_value,
    input  logic [31:0]               issue_alt_pc,
    input  logic                      issue_pred_taken,
    output logic                      rob_full,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
    output logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
    input  logic                      rs_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]               rs_value,
    input  logic                      lsb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
    output logic                      query_ready1,
    output logic                      query_ready2,
    output logic [31:0]               query_value1,
    output logic [31:0]               query_value2,
    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic                      commit_store,
    output logic                      rob_clear,
    output logic [31:0]               clear_pc
);

    localparam int CW = ROB_SIZE_WIDTH + 1;

    rob_state_e          r_state   [ROB_SIZE];
    logic [6:0]          r_type    [ROB_SIZE];
    logic [4:0]          r_rd      [ROB_SIZE];
    logic [31:0]         r_value   [ROB_SIZE];
    logic [31:0]         r_alt_pc  [ROB_SIZE];
    logic                r_pred    [ROB_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] r_head, r_tail;
    logic [CW-1:0]       r_count;

    logic w_full, w_issue, w_retire, w_mispred;

    assign w_full    = (r_count == CW'(ROB_SIZE));
    assign w_issue   = issue_valid && !w_full && !rob_clear;
    assign w_retire  = (r_state[r_head] == ROB_READY) && !rob_clear;
    assign w_mispred = (r_type[r_head] == B_TYPE) && (r_value[r_head][0] != r_pred[r_head]);

    assign rob_full    = w_full;
    assign rob_tail_id = r_tail;
    assign rob_head_id = r_head;

    // A stored result wins; otherwise bypass from this cycle's broadcast, rs first.
    always_comb begin
        query_ready1 = 1'b1;
        query_value1 = '0;
        if (r_state[query_id1] == ROB_READY)           query_value1 = r_value[query_id1];
        else if (rs_ready && rs_rob_id == query_id1)   query_value1 = rs_value;
        else if (lsb_ready && lsb_rob_id == query_id1) query_value1 = lsb_value;
        else                                           query_ready1 = 1'b0;

        query_ready2 = 1'b1;
        query_value2 = '0;
        if (r_state[query_id2] == ROB_READY)           query_value2 = r_value[query_id2];
        else if (rs_ready && rs_rob_id == query_id2)   query_value2 = rs_value;
        else if (lsb_ready && lsb_rob_id == query_id2) query_value2 = lsb_value;
        else                                           query_ready2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            commit_valid  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            commit_store  <= 1'b0;
            rob_clear     <= 1'b0;
            clear_pc      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) r_state[i] <= ROB_EMPTY;
        end else if (rob_clear) begin
            // The flush completes on the edge after the pulse even if rdy drops,
            // so the pulse is never seen twice and the flush is never lost.
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            rob_clear    <= 1'b0;
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) r_state[i] <= ROB_EMPTY;
        end else if (!rdy) begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
        end else begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (rs_ready && rs_rob_id == ROB_SIZE_WIDTH'(i) && r_state[i] == ROB_ISSUED) begin
                    r_value[i] <= rs_value;
                    r_state[i] <= ROB_READY;
                end
                if (lsb_ready && lsb_rob_id == ROB_SIZE_WIDTH'(i) && r_state[i] == ROB_ISSUED) begin
                    r_value[i] <= lsb_value;
                    r_state[i] <= ROB_READY;
                end
            end
            if (w_retire) begin
                r_state[r_head] <= ROB_EMPTY;
                commit_valid    <= writes_rd(r_type[r_head]) && (r_rd[r_head] != 5'd0);
                commit_store    <= (r_type[r_head] == S_TYPE);
                commit_rd       <= r_rd[r_head];
                commit_value    <= r_value[r_head];
                commit_rob_id   <= r_head;
                if (w_mispred) begin
                    rob_clear <= 1'b1;
                    clear_pc  <= r_alt_pc[r_head];
                end
            end
            // Tail entry is EMPTY whenever issue is allowed, so no clash with capture/retire.
            if (w_issue) begin
                r_type[r_tail]   <= issue_type;
                r_rd[r_tail]     <= issue_rd;
                r_alt_pc[r_tail] <= issue_alt_pc;
                r_pred[r_tail]   <= issue_pred_taken;
                r_value[r_tail]  <= issue_value;
                r_state[r_tail]  <= issue_ready ? ROB_READY : ROB_ISSUED;
            end
            r_head  <= r_head + ROB_SIZE_WIDTH'(w_retire);
            r_tail  <= r_tail + ROB_SIZE_WIDTH'(w_issue);
            r_count <= r_count + CW'(w_issue) - CW'(w_retire);
        end
    end

endmodule
